// File: rtl/alu_nibble_sequencer_if.sv
// Request/response bundle between a client and the nibble sequencer.
// The client drives the operation; the sequencer returns the assembled result and status.
interface alu_nibble_sequencer_if #(
    parameter int NIBBLES = 4
) ();
    logic                   start;
    logic [3:0]             op_s;
    logic                   op_m;
    logic                   cin_n;
    logic [4*NIBBLES-1:0]   a;
    logic [4*NIBBLES-1:0]   b;
    logic [4*NIBBLES-1:0]   result;
    logic                   cout_n;
    logic                   eql;
    logic                   busy;
    logic                   done;
    logic [1:0]             dbg_state;

    modport master (
        output start, op_s, op_m, cin_n, a, b,
        input  result, cout_n, eql, busy, done, dbg_state
    );

    modport slave (
        input  start, op_s, op_m, cin_n, a, b,
        output result, cout_n, eql, busy, done, dbg_state
    );
endinterface

// File: rtl/alu_nibble_sequencer.sv
// Runs a WIDTH=4*NIBBLES-bit operation through one 4-bit 74181-style ALU slice,
// one nibble per cycle LSB first, with the active-low ripple carry held in a register.
module alu_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_nibble_sequencer_if.slave bus,
    output logic [3:0]            alu_a,
    output logic [3:0]            alu_b,
    output logic [3:0]            alu_s,
    output logic                  alu_m,
    output logic                  alu_notc,
    input  logic [3:0]            alu_f,
    input  logic                  alu_cout,
    input  logic                  alu_eql
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    // Handshake: start is a one-cycle request taken only in IDLE (busy=0, done=0);
    // requests at any other time are dropped, never queued. done pulses for one
    // cycle once result/cout_n/eql are valid; they then hold until the next accept.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [W-1:0]    a_lat;
    logic [W-1:0]    b_lat;
    logic [3:0]      s_lat;
    logic            m_lat;
    logic            carry_n;
    logic            eql_acc;
    logic [W-1:0]    result_r;
    logic            busy_r;
    logic            done_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            a_lat    <= '0;
            b_lat    <= '0;
            s_lat    <= '0;
            m_lat    <= 1'b0;
            carry_n  <= 1'b1;
            eql_acc  <= 1'b0;
            result_r <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_lat   <= bus.a;
                        b_lat   <= bus.b;
                        s_lat   <= bus.op_s;
                        m_lat   <= bus.op_m;
                        carry_n <= bus.cin_n;
                        idx     <= '0;
                        eql_acc <= 1'b1;
                        busy_r  <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    result_r[{idx, 2'b00} +: 4] <= alu_f;
                    carry_n <= alu_cout;
                    eql_acc <= eql_acc & alu_eql;
                    if (idx == LAST) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // idx is left at the top nibble after DONE, so the operand muxes keep
    // presenting the last nibble while idle; nothing here depends on alu_f.
    always_comb begin
        alu_a    = a_lat[{idx, 2'b00} +: 4];
        alu_b    = b_lat[{idx, 2'b00} +: 4];
        alu_s    = s_lat;
        alu_m    = m_lat;
        alu_notc = (state == RUN) ? carry_n : 1'b1;
    end

    assign bus.result    = result_r;
    assign bus.cout_n    = carry_n;
    assign bus.eql       = eql_acc;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer: a behavioural 74181 slice feeds each DUT, a
// scoreboard queue holds the expected result of every accepted operation.
module tb_alu_nibble_sequencer;
    localparam int N4 = 4;
    localparam int N2 = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_assert;
    int n_fail;

    alu_nibble_sequencer_if #(.NIBBLES(N4)) bus4 ();
    alu_nibble_sequencer_if #(.NIBBLES(N2)) bus2 ();

    logic [3:0] alu_a4, alu_b4, alu_s4, alu_f4;
    logic       alu_m4, alu_notc4, alu_cout4, alu_eql4;
    logic [3:0] alu_a2, alu_b2, alu_s2, alu_f2;
    logic       alu_m2, alu_notc2, alu_cout2, alu_eql2;

    alu_nibble_sequencer #(.NIBBLES(N4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4),
        .alu_a(alu_a4), .alu_b(alu_b4), .alu_s(alu_s4), .alu_m(alu_m4),
        .alu_notc(alu_notc4), .alu_f(alu_f4), .alu_cout(alu_cout4), .alu_eql(alu_eql4)
    );

    alu_nibble_sequencer #(.NIBBLES(N2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_s(alu_s2), .alu_m(alu_m2),
        .alu_notc(alu_notc2), .alu_f(alu_f2), .alu_cout(alu_cout2), .alu_eql(alu_eql2)
    );

    // 74181 active-high data: F = X plus Y plus carry (arith), F = ~(X ^ Y) (logic).
    function automatic logic [5:0] alu181(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] s, input logic m,
                                          input logic cn_n);
        logic [3:0] x, y, f;
        logic [4:0] sum;
        x   = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
        y   = (a & b & {4{s[3]}}) | (a & ~b & {4{s[2]}});
        sum = {1'b0, x} + {1'b0, y} + {4'b0000, ~cn_n};
        f   = m ? ~(x ^ y) : sum[3:0];
        return {(f == 4'hF), ~sum[4], f};
    endfunction

    always_comb {alu_eql4, alu_cout4, alu_f4} = alu181(alu_a4, alu_b4, alu_s4, alu_m4, alu_notc4);
    always_comb {alu_eql2, alu_cout2, alu_f2} = alu181(alu_a2, alu_b2, alu_s2, alu_m2, alu_notc2);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    // entry = {check_cout, cout_n, eql, result}
    logic [18:0] exp_q4[$];
    logic [10:0] exp_q2[$];
    logic [18:0] e4;
    logic [10:0] e2;

    always @(negedge clk) begin
        if (bus4.done === 1'b1) begin
            if (exp_q4.size() == 0) begin
                check("dut4_unexpected_done", 32'(bus4.done), 0);
            end else begin
                e4 = exp_q4.pop_front();
                check("dut4_result", 32'(bus4.result), 32'(e4[15:0]));
                check("dut4_eql", 32'(bus4.eql), 32'(e4[16]));
                if (e4[18]) check("dut4_cout_n", 32'(bus4.cout_n), 32'(e4[17]));
            end
        end
        if (bus2.done === 1'b1) begin
            if (exp_q2.size() == 0) begin
                check("dut2_unexpected_done", 32'(bus2.done), 0);
            end else begin
                e2 = exp_q2.pop_front();
                check("dut2_result", 32'(bus2.result), 32'(e2[7:0]));
                check("dut2_eql", 32'(bus2.eql), 32'(e2[8]));
                if (e2[10]) check("dut2_cout_n", 32'(bus2.cout_n), 32'(e2[9]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue4(input logic [3:0] s, input logic m, input logic cin,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] er, input logic ec, input logic chk_c,
                          input logic ee, input int poke_at,
                          output logic [3:0] notc_hist);
        int cyc;
        @(negedge clk);
        bus4.op_s  = s;
        bus4.op_m  = m;
        bus4.cin_n = cin;
        bus4.a     = a;
        bus4.b     = b;
        bus4.start = 1'b1;
        exp_q4.push_back({chk_c, ec, ee, er});
        @(negedge clk);
        bus4.start = 1'b0;
        bus4.a     = 16'($urandom_range(0, 65535));
        bus4.b     = 16'($urandom_range(0, 65535));
        cyc = 0;
        notc_hist = 4'hF;
        while (bus4.done !== 1'b1 && cyc < 20) begin
            if (bus4.busy === 1'b1 && cyc < 4) notc_hist[cyc[1:0]] = alu_notc4;
            if (cyc == poke_at) begin
                bus4.start = 1'b1;
                bus4.a     = 16'h1111;
            end else begin
                bus4.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus4.start = 1'b0;
        check("dut4_latency", cyc, N4);
        @(negedge clk);
        check("dut4_done_one_cycle", 32'(bus4.done), 0);
        check("dut4_idle_notc", 32'(alu_notc4), 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [3:0]  nh;
        logic [15:0] ra, rb;
        logic [16:0] full;
        int          cyc;

        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus4.start = 1'b0; bus4.op_s = '0; bus4.op_m = 1'b0; bus4.cin_n = 1'b1;
        bus4.a = '0; bus4.b = '0;
        bus2.start = 1'b0; bus2.op_s = '0; bus2.op_m = 1'b0; bus2.cin_n = 1'b1;
        bus2.a = '0; bus2.b = '0;
        repeat (3) @(negedge clk);

        check("rst_state", 32'(bus4.dbg_state), 0);
        check("rst_result", 32'(bus4.result), 0);
        check("rst_cout_n", 32'(bus4.cout_n), 1);
        check("rst_eql", 32'(bus4.eql), 0);
        check("rst_busy", 32'(bus4.busy), 0);
        check("rst_done", 32'(bus4.done), 0);
        check("rst_alu_notc", 32'(alu_notc4), 1);
        check("rst_alu_a", 32'(alu_a4), 0);
        check("rst_alu_b", 32'(alu_b4), 0);
        check("rst_alu_s", 32'(alu_s4), 0);
        check("rst_alu_m", 32'(alu_m4), 0);
        rst = 1'b0;

        issue4(4'b1001, 1'b0, 1'b1, 16'h1234, 16'h0FFF, 16'h2233, 1'b1, 1'b1, 1'b0, -1, nh);
        issue4(4'b1001, 1'b0, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0, -1, nh);
        check("ovf_notc_per_nibble", 32'(nh), 32'h1);

        issue4(4'b0110, 1'b0, 1'b0, 16'h5000, 16'h0001, 16'h4FFF, 1'b0, 1'b1, 1'b0, -1, nh);
        issue4(4'b0110, 1'b0, 1'b0, 16'h0001, 16'h0002, 16'hFFFF, 1'b1, 1'b1, 1'b1, -1, nh);

        issue4(4'b0110, 1'b0, 1'b1, 16'h3C3C, 16'h3C3C, 16'hFFFF, 1'b1, 1'b1, 1'b1, -1, nh);
        issue4(4'b0110, 1'b0, 1'b1, 16'h3C3C, 16'h3C3D, 16'hFFFE, 1'b1, 1'b1, 1'b0, -1, nh);

        issue4(4'b0110, 1'b1, 1'b1, 16'hF0F0, 16'h0FF0, 16'hFF00, 1'b0, 1'b0, 1'b0, 1, nh);
        repeat (4) @(negedge clk);
        check("xor_result_held", 32'(bus4.result), 32'hFF00);
        check("xor_eql_held", 32'(bus4.eql), 0);

        for (int i = 0; i < 3; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            full = {1'b0, ra} + {1'b0, rb};
            issue4(4'b1001, 1'b0, 1'b1, ra, rb, full[15:0], ~full[16], 1'b1,
                   (full[15:0] == 16'hFFFF), -1, nh);
            full = {1'b0, ra} + {1'b0, ~rb} + 17'd1;
            issue4(4'b0110, 1'b0, 1'b0, ra, rb, full[15:0], ~full[16], 1'b1,
                   (full[15:0] == 16'hFFFF), -1, nh);
        end

        // reset in the middle of an operation
        @(negedge clk);
        bus4.op_s = 4'b1001; bus4.op_m = 1'b0; bus4.cin_n = 1'b1;
        bus4.a = 16'h7777; bus4.b = 16'h1111; bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        repeat (2) @(negedge clk);
        check("midop_busy", 32'(bus4.busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_state", 32'(bus4.dbg_state), 0);
        check("midrst_busy", 32'(bus4.busy), 0);
        check("midrst_result", 32'(bus4.result), 0);
        check("midrst_cout_n", 32'(bus4.cout_n), 1);
        check("midrst_alu_notc", 32'(alu_notc4), 1);
        repeat (8) @(negedge clk);

        // start together with reset: reset wins
        rst = 1'b1; bus4.start = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus4.start = 1'b0;
        check("rst_start_state", 32'(bus4.dbg_state), 0);
        check("rst_start_busy", 32'(bus4.busy), 0);
        repeat (6) @(negedge clk);

        issue4(4'b1001, 1'b0, 1'b1, 16'h8421, 16'h1357, 16'h9778, 1'b1, 1'b1, 1'b0, -1, nh);

        // two-nibble instance
        @(negedge clk);
        bus2.op_s = 4'b1001; bus2.op_m = 1'b0; bus2.cin_n = 1'b1;
        bus2.a = 8'hFF; bus2.b = 8'h01; bus2.start = 1'b1;
        exp_q2.push_back({1'b1, 1'b0, 1'b0, 8'h00});
        @(negedge clk);
        bus2.start = 1'b0;
        cyc = 0;
        while (bus2.done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("dut2_latency", cyc, N2);
        repeat (3) @(negedge clk);

        check("dut4_queue_drained", exp_q4.size(), 0);
        check("dut2_queue_drained", exp_q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
